// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame-sequencing FSM for the UART receiver.
// Detects the start-bit falling edge, then walks through start, data, optional parity and stop
// bit periods using the external edge/bit counter. It gates the counter, sampler, deserializer
// and checkers, and raises one data_valid or error pulse per completed frame.
//
// Ports:
//   clk, rst_n      system clock (prescale x baud), async active-low reset
//   RX_IN           synchronised serial line, idle high
//   PAR_EN          parity enable, latched at frame start into par_en_q
//   prescale        oversampling ratio (8/16/32), static while busy
//   bit_cnt         counter bit index (0 start, 1..DATA_BITS data, then parity/stop)
//   edge_cnt        counter edge index within a bit, 0..prescale-1
//   strt_glitch     start checker result (valid with strt_chk_en)
//   par_err         parity checker result (valid with par_chk_en)
//   stp_err         stop checker result (valid with stp_chk_en)
//   cnt_en/cnt_clr  counter enable / synchronous clear
//   par_en_q        latched parity enable for the whole frame
//   dat_samp_en     majority-sampler enable
//   deser_en        one-cycle deserializer shift strobe
//   strt/par/stp_chk_en  one-cycle checker strobes
//   data_valid      one-cycle good-frame pulse
//   parity_error    one-cycle parity error pulse
//   framing_error   one-cycle stop-bit error pulse
//   busy            high whenever not idle
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PRESC_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [3:0]         bit_cnt,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               par_en_q,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               parity_error,
  output logic               framing_error,
  output logic               busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  localparam logic [3:0] LastData = 4'(DATA_BITS);

  state_e r_state;
  logic   r_par_en;
  logic   r_err_p;
  logic   r_err_s;

  logic [PRESC_W-1:0] w_strb;
  logic [PRESC_W-1:0] w_end;
  logic               w_at_strb;
  logic               w_at_end;

  // Sampler takes mid-1, mid, mid+1; its majority result is settled two edges past mid.
  assign w_strb    = (prescale >> 1) + PRESC_W'(2);
  assign w_end     = prescale - PRESC_W'(1);
  assign w_at_strb = (edge_cnt == w_strb);
  assign w_at_end  = (edge_cnt == w_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_par_en <= 1'b0;
      r_err_p  <= 1'b0;
      r_err_s  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!RX_IN) begin
            r_state  <= StStart;
            r_par_en <= PAR_EN;
            r_err_p  <= 1'b0;
            r_err_s  <= 1'b0;
          end
        end
        StStart: begin
          // A glitch aborts silently; IDLE clears the counter for the next attempt.
          if (w_at_strb && strt_glitch) begin
            r_state <= StIdle;
          end else if (w_at_end) begin
            r_state <= StData;
          end
        end
        StData: begin
          if (w_at_end && (bit_cnt == LastData)) begin
            r_state <= r_par_en ? StParity : StStop;
          end
        end
        StParity: begin
          if (w_at_strb) begin
            r_err_p <= par_err;
          end
          if (w_at_end) begin
            r_state <= StStop;
          end
        end
        StStop: begin
          // Leave at the stop strobe so a start edge right after the stop bit is caught.
          if (w_at_strb) begin
            r_err_s <= stp_err;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  logic w_in_frame;
  logic w_done;

  assign w_in_frame = (r_state == StStart) || (r_state == StData) ||
                      (r_state == StParity) || (r_state == StStop);
  assign w_done     = (r_state == StDone);

  assign cnt_en        = w_in_frame;
  assign dat_samp_en   = w_in_frame;
  assign cnt_clr       = (r_state == StIdle) || w_done;
  assign par_en_q      = r_par_en;
  assign strt_chk_en   = (r_state == StStart)  && w_at_strb;
  assign deser_en      = (r_state == StData)   && w_at_strb;
  assign par_chk_en    = (r_state == StParity) && w_at_strb;
  assign stp_chk_en    = (r_state == StStop)   && w_at_strb;
  assign data_valid    = w_done && !r_err_s && !(r_par_en && r_err_p);
  assign parity_error  = w_done && r_par_en && r_err_p;
  assign framing_error = w_done && r_err_s;
  assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl. A small counter model drives bit_cnt/edge_cnt; a negedge
// monitor accumulates pulse counts and timing which the main sequence compares against
// hand-computed values.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst_n;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] prescale;
  logic [3:0] bit_cnt;
  logic [5:0] edge_cnt;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       cnt_en;
  logic       cnt_clr;
  logic       par_en_q;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  uart_rx_ctrl #(
    .DATA_BITS(8),
    .PRESC_W  (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .prescale     (prescale),
    .bit_cnt      (bit_cnt),
    .edge_cnt     (edge_cnt),
    .strt_glitch  (strt_glitch),
    .par_err      (par_err),
    .stp_err      (stp_err),
    .cnt_en       (cnt_en),
    .cnt_clr      (cnt_clr),
    .par_en_q     (par_en_q),
    .dat_samp_en  (dat_samp_en),
    .deser_en     (deser_en),
    .strt_chk_en  (strt_chk_en),
    .par_chk_en   (par_chk_en),
    .stp_chk_en   (stp_chk_en),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker results are bench-controlled flags.
  logic glitch_v, par_err_v, stp_err_v;
  assign strt_glitch = glitch_v;
  assign par_err     = par_err_v;
  assign stp_err     = stp_err_v;

  // Shared edge/bit counter model.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (cnt_clr) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (cnt_en) begin
      if (edge_cnt == prescale - 6'd1) begin
        edge_cnt <= 6'd0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
    end
  end

  // Monitor: cumulative counts; cyc = cycles since START entry of the current frame.
  int         cyc, n_deser, n_strt, n_par, n_dv, n_pe, n_fe, n_ovl, n_bad_edge, n_presc_chg;
  int         dv_cyc;
  logic [3:0] par_bit;
  logic [5:0] par_edge, presc_lat;
  logic [7:0] cap, dv_byte;
  logic [5:0] exp_strb;

  initial begin
    cyc = 0; n_deser = 0; n_strt = 0; n_par = 0; n_dv = 0; n_pe = 0; n_fe = 0;
    n_ovl = 0; n_bad_edge = 0; n_presc_chg = 0; dv_cyc = -1;
    par_bit = '0; par_edge = '0; presc_lat = '0; cap = '0; dv_byte = '0;
  end

  always @(negedge clk) begin
    if (!busy) begin
      cyc       <= 0;
      cap       <= 8'h00;
      presc_lat <= prescale;
    end else begin
      cyc <= cyc + 1;
      if (prescale != presc_lat) n_presc_chg <= n_presc_chg + 1;
    end
    if (deser_en) begin
      n_deser <= n_deser + 1;
      cap     <= {RX_IN, cap[7:1]};
      if (edge_cnt != exp_strb) n_bad_edge <= n_bad_edge + 1;
    end
    if (strt_chk_en) n_strt <= n_strt + 1;
    if (par_chk_en) begin
      n_par    <= n_par + 1;
      par_bit  <= bit_cnt;
      par_edge <= edge_cnt;
    end
    if (data_valid) begin
      n_dv    <= n_dv + 1;
      dv_cyc  <= cyc;
      dv_byte <= cap;
    end
    if (parity_error) n_pe <= n_pe + 1;
    if (framing_error) n_fe <= n_fe + 1;
    if (data_valid && (parity_error || framing_error)) n_ovl <= n_ovl + 1;
  end

  int total, bad;
  int s_deser, s_strt, s_par, s_dv, s_pe, s_fe;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic snap();
    s_deser = n_deser; s_strt = n_strt; s_par = n_par;
    s_dv = n_dv; s_pe = n_pe; s_fe = n_fe;
  endtask

  // Drives a full frame; cycle c after START entry carries frame bit c/prescale.
  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic pbit,
                            input logic sbit, input int tog_cyc);
    logic [10:0] fr;
    int          p, nbits;
    p     = int'(prescale);
    fr    = '1;
    fr[0] = 1'b0;
    fr[8:1] = d;
    if (with_par) begin
      fr[9]  = pbit;
      fr[10] = sbit;
      nbits  = 11;
    end else begin
      fr[9] = sbit;
      nbits = 10;
    end
    RX_IN = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < nbits * p; c++) begin
      RX_IN = fr[c / p];
      if (c == tog_cyc) PAR_EN = 1'b0;
      @(posedge clk); #1;
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
    glitch_v = 1'b0; par_err_v = 1'b0; stp_err_v = 1'b0; exp_strb = 6'd6;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_par_en_q", int'(par_en_q), 0);
    chk("rst_errors", int'({parity_error, framing_error}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_cnt_clr", int'(cnt_clr), 1);

    // 1: prescale 8, no parity, 0x5A, good stop.
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
    chk("f1_deser_cnt", n_deser - s_deser, 8);
    chk("f1_dv_cnt", n_dv - s_dv, 1);
    chk("f1_dv_cycle", dv_cyc, 79);
    chk("f1_byte", int'(dv_byte), 32'h5A);
    chk("f1_no_err", (n_pe - s_pe) + (n_fe - s_fe), 0);
    chk("f1_idle", int'(busy), 0);

    // 2: parity enabled, 0xA5 (even parity bit 0).
    repeat (3) @(posedge clk); #1;
    PAR_EN = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
    chk("f2_par_chk_cnt", n_par - s_par, 1);
    chk("f2_par_bit", int'(par_bit), 9);
    chk("f2_par_edge", int'(par_edge), 6);
    chk("f2_dv_cycle", dv_cyc, 87);
    chk("f2_dv_cnt", n_dv - s_dv, 1);
    chk("f2_byte", int'(dv_byte), 32'hA5);

    // 3: same frame, parity checker reports error.
    repeat (3) @(posedge clk); #1;
    par_err_v = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1);
    par_err_v = 1'b0;
    chk("f3_pe_cnt", n_pe - s_pe, 1);
    chk("f3_dv_cnt", n_dv - s_dv, 0);
    chk("f3_fe_cnt", n_fe - s_fe, 0);

    // 4: prescale 16, 4-cycle low glitch rejected at edge 10.
    PAR_EN = 1'b0;
    repeat (3) @(posedge clk); #1;
    prescale = 6'd16;
    glitch_v = 1'b1;
    snap();
    RX_IN = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    RX_IN = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    glitch_v = 1'b0;
    chk("g_strt_chk_cnt", n_strt - s_strt, 1);
    chk("g_deser_cnt", n_deser - s_deser, 0);
    chk("g_no_pulse", (n_dv - s_dv) + (n_pe - s_pe) + (n_fe - s_fe), 0);
    chk("g_idle", int'(busy), 0);
    chk("g_cnt_clr", int'(cnt_clr), 1);

    // 5: prescale 8, bad stop bit.
    prescale = 6'd8;
    repeat (2) @(posedge clk); #1;
    stp_err_v = 1'b1;
    snap();
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, -1);
    stp_err_v = 1'b0;
    chk("f5_fe_cnt", n_fe - s_fe, 1);
    chk("f5_dv_cnt", n_dv - s_dv, 0);
    chk("f5_pe_cnt", n_pe - s_pe, 0);

    // 6: back-to-back frames, second start edge right after DONE.
    repeat (3) @(posedge clk); #1;
    snap();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1);
    chk("b2b_first_byte", int'(dv_byte), 32'hC3);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1);
    chk("b2b_dv_cnt", n_dv - s_dv, 2);
    chk("b2b_second_byte", int'(dv_byte), 32'h96);
    chk("b2b_dv_cycle", dv_cyc, 79);

    // 7: reset mid-frame at data bit 4, then a clean frame.
    repeat (3) @(posedge clk); #1;
    PAR_EN = 1'b1;
    snap();
    RX_IN = 1'b0;
    @(posedge clk); #1;
    RX_IN = 1'b1;
    for (int i = 0; i < 200 && bit_cnt != 4'd4; i++) begin
      @(posedge clk); #1;
    end
    chk("rm_reach_bit4", int'(bit_cnt), 4);
    chk("rm_par_en_q_set", int'(par_en_q), 1);
    rst_n = 1'b0;
    #1;
    chk("rm_busy", int'(busy), 0);
    chk("rm_enables", int'({cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                            stp_chk_en}), 0);
    chk("rm_pulses", int'({data_valid, parity_error, framing_error}), 0);
    chk("rm_par_en_q", int'(par_en_q), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    PAR_EN = 1'b0;
    @(posedge clk); #1;
    chk("rm_no_dv", n_dv - s_dv, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    chk("rm_next_dv", n_dv - s_dv, 1);
    chk("rm_next_byte", int'(dv_byte), 32'h3C);

    // 8: PAR_EN drops mid-DATA; frame still uses parity (0x81 even parity bit 0).
    repeat (3) @(posedge clk); #1;
    PAR_EN = 1'b1;
    snap();
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 30);
    chk("tog_par_chk_cnt", n_par - s_par, 1);
    chk("tog_dv_cycle", dv_cyc, 87);
    chk("tog_byte", int'(dv_byte), 32'h81);

    chk("deser_edge_all", n_bad_edge, 0);
    chk("no_dv_err_overlap", n_ovl, 0);
    chk("prescale_static_busy", n_presc_chg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
